// File: rtl/stat_pipe_sig.sv
// stat_pipe_sig: STAGES-deep registered bit-transform pipeline with a global stall,
// feeding a MISR signature and a saturating count of accepted results.
module stat_pipe_sig #(
  parameter int             W      = 8,
  parameter int             STAGES = 3,
  parameter logic [W-1:0]   POLY   = 'h1D,
  parameter int             CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             bypass,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  input  logic             sig_clear,
  output logic [W-1:0]     signature,
  output logic [CNT_W-1:0] vec_cnt
);

  logic [W-1:0]      stage_data [STAGES];
  logic [STAGES-1:0] stage_vld;
  logic              adv;
  logic              accept;

  // The whole pipeline moves in lockstep: any stall freezes every stage, bubbles included.
  assign adv       = !stage_vld[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = stage_vld[STAGES-1];
  assign out_data  = stage_data[STAGES-1];
  assign accept    = out_valid && out_ready;

  function automatic logic [W-1:0] xform(input logic [W-1:0] x, input logic byp);
    logic [W-1:0] y;
    for (int i = 0; i < W; i++) begin
      y[i] = x[i] ^ (x[(i+1)%W] & ~x[(i+2)%W]);
    end
    return byp ? x : y;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_data[k] <= '0;
      end
    end else if (adv) begin
      stage_vld[0]  <= in_valid;
      stage_data[0] <= xform(in_data, bypass);
      for (int k = 1; k < STAGES; k++) begin
        stage_vld[k]  <= stage_vld[k-1];
        stage_data[k] <= xform(stage_data[k-1], bypass);
      end
    end
  end

  // Clear wins over a same-cycle accept; only handshaken results reach the MISR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= '0;
      vec_cnt   <= '0;
    end else if (sig_clear) begin
      signature <= '0;
      vec_cnt   <= '0;
    end else if (accept) begin
      signature <= {signature[W-2:0], signature[W-1]} ^ out_data ^
                   (signature[W-1] ? POLY : '0);
      if (vec_cnt != '1) begin
        vec_cnt <= vec_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stat_pipe_sig.sv
// tb_stat_pipe_sig: directed checks on a single-stage instance plus a scoreboarded
// three-stage instance with backpressure, clear, counter saturation and mid-stream reset.
module tb_stat_pipe_sig;

  localparam logic [7:0] POLY = 8'h1D;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_bypass, a_out_valid, a_out_ready, a_sig_clear;
  logic [7:0]  a_in_data, a_out_data, a_signature;
  logic [15:0] a_vec_cnt;

  logic        b_in_valid, b_in_ready, b_bypass, b_out_valid, b_out_ready, b_sig_clear;
  logic [7:0]  b_in_data, b_out_data, b_signature;
  logic [3:0]  b_vec_cnt;

  stat_pipe_sig #(.W(8), .STAGES(1), .POLY(POLY), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .bypass(a_bypass), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .sig_clear(a_sig_clear),
    .signature(a_signature), .vec_cnt(a_vec_cnt)
  );

  stat_pipe_sig #(.W(8), .STAGES(3), .POLY(POLY), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .bypass(b_bypass), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .sig_clear(b_sig_clear),
    .signature(b_signature), .vec_cnt(b_vec_cnt)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];
  logic [7:0] m_sig;
  logic [3:0] m_cnt;
  logic       stall_prev;
  logic [7:0] held;
  logic       last_taken;

  // Independent form of the stage transform: rotate-right views of x give x[i+1], x[i+2].
  function automatic logic [7:0] f_model(input logic [7:0] x);
    return x ^ ({x[0], x[7:1]} & ~{x[1:0], x[7:2]});
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on the 3-stage instance: verify last edge's effects, drive, then score handshakes.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ordy,
                               input logic byp, input logic clr);
    logic [7:0] exp;
    @(negedge clk);
    checkOutput("b_signature", b_signature, m_sig);
    checkOutput("b_vec_cnt", b_vec_cnt, m_cnt);
    if (stall_prev) begin
      checkOutput("b_hold_data", b_out_data, held);
      checkOutput("b_hold_valid", b_out_valid, 1);
    end
    b_in_valid  = v;
    b_in_data   = d;
    b_out_ready = ordy;
    b_bypass    = byp;
    b_sig_clear = clr;
    #1;
    checkOutput("b_in_ready", b_in_ready, !b_out_valid || ordy);
    if (b_out_valid && ordy) begin
      checkOutput("b_sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        checkOutput("b_out_data", b_out_data, exp);
        if (!clr) begin
          m_sig = {m_sig[6:0], m_sig[7]} ^ exp ^ (m_sig[7] ? POLY : 8'h00);
          if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end
      end
    end
    if (clr) begin
      m_sig = 8'h00;
      m_cnt = 4'h0;
    end
    stall_prev = b_out_valid && !ordy;
    held       = b_out_data;
    last_taken = v && b_in_ready;
    if (last_taken) sb_q.push_back(byp ? d : f_model(f_model(f_model(d))));
  endtask

  task automatic drain(input logic byp);
    for (int i = 0; i < 12 && sb_q.size() != 0; i++) applyStimulus(1'b0, 8'h00, 1'b1, byp, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, byp, 1'b0);
    checkOutput("b_drained", sb_q.size(), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_bypass = 0; a_out_ready = 1; a_sig_clear = 0;
    b_in_valid = 0; b_in_data = 0; b_bypass = 0; b_out_ready = 1; b_sig_clear = 0;
    m_sig = 0; m_cnt = 0; stall_prev = 0; held = 0; last_taken = 0;

    @(negedge clk);
    checkOutput("a_rst_out_valid", a_out_valid, 0);
    checkOutput("a_rst_in_ready", a_in_ready, 1);
    checkOutput("b_rst_out_valid", b_out_valid, 0);
    checkOutput("b_rst_in_ready", b_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("a_rst_out_data", a_out_data, 8'h00);
    checkOutput("a_rst_signature", a_signature, 8'h00);
    checkOutput("a_rst_vec_cnt", a_vec_cnt, 16'h0);

    // Single-stage transform and MISR against hand-derived values.
    a_in_valid = 1; a_in_data = 8'h01;
    @(negedge clk);
    checkOutput("a_out_valid_1", a_out_valid, 1);
    checkOutput("a_f_01", a_out_data, 8'h81);
    checkOutput("a_in_ready", a_in_ready, 1);
    a_in_data = 8'hFF;
    @(negedge clk);
    checkOutput("a_f_ff", a_out_data, 8'hFF);
    checkOutput("a_sig_1", a_signature, 8'h81);
    checkOutput("a_cnt_1", a_vec_cnt, 16'd1);
    a_in_data = 8'h00;
    @(negedge clk);
    checkOutput("a_f_00", a_out_data, 8'h00);
    checkOutput("a_sig_2", a_signature, 8'hE1);
    checkOutput("a_cnt_2", a_vec_cnt, 16'd2);
    a_in_valid = 0; a_sig_clear = 1;
    @(negedge clk);
    checkOutput("a_clr_valid", a_out_valid, 0);
    checkOutput("a_clr_sig", a_signature, 8'h00);
    checkOutput("a_clr_cnt", a_vec_cnt, 16'd0);
    a_sig_clear = 0; a_in_valid = 1; a_in_data = 8'h01;
    @(negedge clk);
    checkOutput("a_post_clr_data", a_out_data, 8'h81);
    a_in_valid = 0;
    @(negedge clk);
    checkOutput("a_post_clr_sig", a_signature, 8'h81);
    checkOutput("a_post_clr_cnt", a_vec_cnt, 16'd1);
    checkOutput("a_idle_valid", a_out_valid, 0);

    // Continuous stream with a 4-cycle output stall in the middle.
    k = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(k * 37), !(i >= 6 && i < 10), 1'b0, 1'b0);
      if (last_taken) k++;
    end
    drain(1'b0);

    // Clear, then 20 accepts into the 4-bit counter.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i * 11 + 3), 1'b1, 1'b0, 1'b0);
    drain(1'b0);
    checkOutput("b_cnt_sat", b_vec_cnt, 4'hF);

    // Mid-stream reset with three vectors in flight.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("b_pre_rst_valid", b_out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("b_rst_mid_valid", b_out_valid, 0);
    checkOutput("b_rst_mid_data", b_out_data, 8'h00);
    checkOutput("b_rst_mid_ready", b_in_ready, 1);
    checkOutput("b_rst_mid_cnt", b_vec_cnt, 4'h0);
    b_in_valid = 0;
    sb_q.delete();
    m_sig = 0; m_cnt = 0; stall_prev = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i * 5), 1'b1, 1'b1, 1'b0);
      if (i < 3) checkOutput("b_no_stale", b_out_valid, 0);
    end
    drain(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
